// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
// Holds the line count, the encoded vector width and the delivery FSM states.
package irq_pkg;

  localparam int NUM_IRQ  = 8;
  localparam int IRQ_ID_W = 3;

  // IDLE evaluates the candidates; PRESENT holds one vector until accepted.
  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

endpackage

// File: rtl/irq_pri_enc8.sv
// Eight-input priority encoder.
// Ports:
//   req  - candidate lines, bit 7 has highest priority
//   idx  - index of the highest set bit of req (0 when req is 0)
//   any  - at least one bit of req is set
module irq_pri_enc8
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0]  req,
  output logic [IRQ_ID_W-1:0] idx,
  output logic                any
);

  // Scan upward so that a higher set bit overwrites any lower one, leaving
  // the index of the highest-priority request.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i]) begin
        idx = IRQ_ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: rising-edge detection on eight request lines, a
// pending register, sticky overflow and delivery of the highest-priority
// unmasked pending line over a valid/ready handshake.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   irq_in      - request lines; each 0->1 transition is one request
//   mask        - 1 enables a line for delivery (masked lines still latch)
//   vec_valid   - a vector is offered
//   vec_ready   - consumer accepts when vec_valid & vec_ready
//   vec_id      - offered line index, frozen while offered
//   pending     - current pending register
//   overflow    - sticky, a rise hit a line that was already pending
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  mask,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic [IRQ_ID_W-1:0] vec_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                overflow
);

  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  clr;
  logic [NUM_IRQ-1:0]  cand;
  logic [IRQ_ID_W-1:0] enc_idx;
  logic                enc_any;
  logic                handshake;
  logic                load_id;
  state_t              state, next_state;

  // Edge detection, handshake decode and the one-hot clear of the accepted
  // line. The clear only exists while a vector is actually being offered,
  // so vec_ready in IDLE has no effect.
  always_comb begin
    rise      = irq_in & ~irq_q;
    handshake = (state == PRESENT) && vec_ready;
    clr       = handshake ? (NUM_IRQ'(1) << vec_id) : '0;
    cand      = pending & mask;
  end

  irq_pri_enc8 u_enc (
    .req (cand),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Request bookkeeping. A new rise and a clear on the same line keep the
  // line pending: the fresh request is a distinct event and is not an
  // overflow because the old one was just consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~clr) | rise;
      if (|(rise & pending & ~clr)) begin
        overflow <= 1'b1;
      end
    end
  end

  // Delivery FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and offer logic. The winner is chosen only in IDLE, so a
  // mask change or higher-priority arrival never retracts an offer.
  always_comb begin
    next_state = state;
    vec_valid  = 1'b0;
    load_id    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enc_any) begin
          load_id    = 1'b1;
          next_state = PRESENT;
        end
      end
      PRESENT: begin
        vec_valid = 1'b1;
        if (vec_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Offered index register, captured on the IDLE->PRESENT transition and
  // otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_id <= '0;
    end else if (load_id) begin
      vec_id <= enc_idx;
    end
  end

endmodule
